// File: rtl/led_chaser_pkg.sv
// Shared constants and divider-limit helper for the LED chaser.
package led_chaser_pkg;

  localparam logic DIR_FWD     = 1'b0;
  localparam logic DIR_BWD     = 1'b1;
  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Terminal count of the step divider at speed level k (level 0 fastest).
  function automatic logic [63:0] div_limit(input int unsigned clk_hz,
                                            input int unsigned base_hz,
                                            input int unsigned k);
    return (64'(clk_hz / base_hz) << k) - 64'd1;
  endfunction

endpackage

// File: rtl/led_chaser_step_tick_gen.sv
// Step-rate divider plus speed-level register; emits a one-cycle tick
// at the rate selected by speed_idx.
module step_tick_gen
  import led_chaser_pkg::*;
#(
  parameter int unsigned N_SPEEDS = 4,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BASE_HZ  = 16,
  parameter int unsigned SW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          speed_pls,
  output logic          tick,
  output logic [SW-1:0] speed_idx
);

  // Counter sized for the slowest level's terminal count.
  localparam int unsigned CW = $clog2(div_limit(CLK_HZ, BASE_HZ, N_SPEEDS - 1) + 64'd1);

  logic [CW-1:0] cnt_q, cnt_d, limit;
  logic [SW-1:0] idx_q, idx_d;
  logic          at_limit;

  // Next count/level; a speed change restarts the count and swallows a tick.
  always_comb begin
    limit    = CW'(div_limit(CLK_HZ, BASE_HZ, 32'(idx_q)));
    at_limit = (cnt_q == limit);
    tick     = at_limit & ~speed_pls;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CW'(1);
    if (speed_pls) begin
      cnt_d = '0;
      if (N_SPEEDS > 1)
        idx_d = (idx_q == SW'(N_SPEEDS - 1)) ? '0 : idx_q + SW'(1);
      else
        idx_d = '0;
    end else if (at_limit) begin
      cnt_d = '0;
    end
  end

  // Divider and speed level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign speed_idx = idx_q;

endmodule

// File: rtl/led_chaser.sv
// Running-light engine: one lit (low) LED walks the bar at a selectable
// speed and direction. Define LED_CHASER_BOUNCE_EN to enable the
// ping-pong mode toggled by mode_pls; otherwise the bar always wraps.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int unsigned N_LEDS   = 10,
  parameter int unsigned N_SPEEDS = 4,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BASE_HZ  = 16,
  localparam int unsigned SW      = (N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              speed_pls,
  input  logic              dir_pls,
  input  logic              mode_pls,
  output logic [N_LEDS-1:0] led_n,
  output logic [SW-1:0]     speed_idx,
  output logic              dir,
  output logic              bounce,
  output logic              step
);

  localparam int unsigned PW   = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  logic              tick;
  logic [PW-1:0]     pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              bounce_q, bounce_d;
  logic              step_q;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              autorev;

  step_tick_gen #(
    .N_SPEEDS (N_SPEEDS),
    .CLK_HZ   (CLK_HZ),
    .BASE_HZ  (BASE_HZ),
    .SW       (SW)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .speed_pls (speed_pls),
    .tick      (tick),
    .speed_idx (speed_idx)
  );

`ifndef LED_CHASER_BOUNCE_EN
  logic unused_mode;
  assign unused_mode = mode_pls;
`endif

  // Position walk on tick using the current dir; end-of-bar reversal in
  // bounce mode XORs with a user dir press so the two cancel.
  always_comb begin
    pos_d   = pos_q;
    autorev = 1'b0;
    if (tick) begin
      if (bounce_q == MODE_BOUNCE) begin
        if (dir_q == DIR_FWD) begin
          if (pos_q == LAST) begin
            pos_d   = LAST - PW'(1);
            autorev = 1'b1;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          if (pos_q == '0) begin
            pos_d   = PW'(1);
            autorev = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end else begin
        if (dir_q == DIR_FWD)
          pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
        else
          pos_d = (pos_q == '0) ? LAST : pos_q - PW'(1);
      end
    end
    dir_d = dir_q ^ dir_pls ^ autorev;
`ifdef LED_CHASER_BOUNCE_EN
    bounce_d = bounce_q ^ mode_pls;
`else
    bounce_d = MODE_WRAP;
`endif
    for (int i = 0; i < int'(N_LEDS); i++)
      led_d[i] = (pos_d != PW'(i));
  end

  // Walker state and registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= '0;
      dir_q    <= DIR_FWD;
      bounce_q <= MODE_WRAP;
      step_q   <= 1'b0;
      led_q    <= {{(N_LEDS-1){1'b1}}, 1'b0};
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      step_q   <= tick;
      led_q    <= led_d;
    end
  end

  assign led_n  = led_q;
  assign dir    = dir_q;
  assign bounce = bounce_q;
  assign step   = step_q;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser with N_LEDS=4, N_SPEEDS=3, LIMIT 3/7/15.
module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst, speed_pls, dir_pls, mode_pls;
  logic [3:0] led_n;
  logic [1:0] speed_idx;
  logic       dir, bounce, step;

  int total = 0;
  int bad   = 0;

  led_chaser #(
    .N_LEDS   (4),
    .N_SPEEDS (3),
    .CLK_HZ   (64),
    .BASE_HZ  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .speed_pls (speed_pls),
    .dir_pls   (dir_pls),
    .mode_pls  (mode_pls),
    .led_n     (led_n),
    .speed_idx (speed_idx),
    .dir       (dir),
    .bounce    (bounce),
    .step      (step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sp, dp, mp;
    int         gap;
    logic [3:0] led;
    int         idx;
    logic       dr, bn;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic sp, logic dp, logic mp, int gap,
                              logic [3:0] led, int idx, logic dr, logic bn);
    vec_t v;
    v.sp = sp; v.dp = dp; v.mp = mp; v.gap = gap;
    v.led = led; v.idx = idx; v.dr = dr; v.bn = bn;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Apply pulses for one cycle, then run until a step appears (bounded).
  task automatic run_to_step(input logic sp, input logic dp, input logic mp,
                             output int n);
    speed_pls = sp; dir_pls = dp; mode_pls = mp;
    cyc();
    speed_pls = 0; dir_pls = 0; mode_pls = 0;
    n = 1;
    while (!step && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_led"},  32'(led_n), 32'b1110);
    chk({nm, "_idx"},  32'(speed_idx), 0);
    chk({nm, "_dir"},  32'(dir), 0);
    chk({nm, "_bnc"},  32'(bounce), 0);
    chk({nm, "_step"}, 32'(step), 0);
  endtask

  initial begin
    int n;
    rst = 1; speed_pls = 0; dir_pls = 0; mode_pls = 0;
    cyc();
    rst = 0;
    chk_reset("rst");

    // plain walk at level 0
    vq.push_back(mk(0,0,0, 4, 4'b1101, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b1011, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b0111, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b1110, 0, 0, 0));
    // speed levels, including wrap back to 0
    vq.push_back(mk(1,0,0, 9, 4'b1101, 1, 0, 0));
    vq.push_back(mk(0,0,0, 8, 4'b1011, 1, 0, 0));
    vq.push_back(mk(1,0,0,17, 4'b0111, 2, 0, 0));
    vq.push_back(mk(1,0,0, 5, 4'b1110, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b1101, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b1011, 0, 0, 0));
    // reverse at pos 2, backward wrap 0 -> 3, then forward wrap 3 -> 0
    vq.push_back(mk(0,1,0, 4, 4'b1101, 0, 1, 0));
    vq.push_back(mk(0,0,0, 4, 4'b1110, 0, 1, 0));
    vq.push_back(mk(0,0,0, 4, 4'b0111, 0, 1, 0));
    vq.push_back(mk(0,1,0, 4, 4'b1110, 0, 0, 0));
`ifdef LED_CHASER_BOUNCE_EN
    vq.push_back(mk(0,0,1, 4, 4'b1101, 0, 0, 1));
    vq.push_back(mk(0,0,0, 4, 4'b1011, 0, 0, 1));
    vq.push_back(mk(0,0,0, 4, 4'b0111, 0, 0, 1));
    vq.push_back(mk(0,0,0, 4, 4'b1011, 0, 1, 1));
    vq.push_back(mk(0,0,0, 4, 4'b1101, 0, 1, 1));
    vq.push_back(mk(0,0,0, 4, 4'b1110, 0, 1, 1));
    vq.push_back(mk(0,0,0, 4, 4'b1101, 0, 0, 1));
    vq.push_back(mk(0,0,0, 4, 4'b1011, 0, 0, 1));
    vq.push_back(mk(0,0,0, 4, 4'b0111, 0, 0, 1));
`else
    vq.push_back(mk(0,0,1, 4, 4'b1101, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b1011, 0, 0, 0));
    vq.push_back(mk(0,0,0, 4, 4'b0111, 0, 0, 0));
`endif

    foreach (vq[i]) begin
      run_to_step(vq[i].sp, vq[i].dp, vq[i].mp, n);
      chk($sformatf("v%0d_gap", i), 32'(n), 32'(vq[i].gap));
      chk($sformatf("v%0d_led", i), 32'(led_n), 32'(vq[i].led));
      chk($sformatf("v%0d_idx", i), 32'(speed_idx), 32'(vq[i].idx));
      chk($sformatf("v%0d_dir", i), 32'(dir), 32'(vq[i].dr));
      chk($sformatf("v%0d_bnc", i), 32'(bounce), 32'(vq[i].bn));
    end

    // dir_pls on the tick cycle at pos 3 going forward
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("pre_tick%0d_step", k), 32'(step), 0);
    end
    dir_pls = 1;
    cyc();
    dir_pls = 0;
    chk("dtick_step", 32'(step), 1);
`ifdef LED_CHASER_BOUNCE_EN
    chk("dtick_led", 32'(led_n), 32'b1011);
    chk("dtick_dir", 32'(dir), 0);
`else
    chk("dtick_led", 32'(led_n), 32'b1110);
    chk("dtick_dir", 32'(dir), 1);
`endif

    // speed_pls on the tick cycle suppresses that step
    for (int k = 0; k < 3; k++) cyc();
    speed_pls = 1;
    cyc();
    speed_pls = 0;
    chk("stick_step", 32'(step), 0);
    chk("stick_idx", 32'(speed_idx), 1);
    n = 0;
    while (!step && n < 40) begin
      cyc();
      n++;
    end
    chk("stick_gap", 32'(n), 8);
    chk("stick_led", 32'(led_n), 32'b0111);

    // reset mid-walk at level 2 with every pulse asserted
    speed_pls = 1;
    cyc();
    speed_pls = 0;
    chk("pre_rst_idx", 32'(speed_idx), 2);
    for (int k = 0; k < 5; k++) cyc();
    rst = 1; speed_pls = 1; dir_pls = 1; mode_pls = 1;
    cyc();
    rst = 0; speed_pls = 0; dir_pls = 0; mode_pls = 0;
    chk_reset("midrst");
    run_to_step(0, 0, 0, n);
    chk("post_rst_gap", 32'(n), 4);
    chk("post_rst_led", 32'(led_n), 32'b1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
